sram_req_ctrl: RTL and testbench

Request-side controller that drives the 1RW port of the banked SRAM wrapper (csb/web/wmask/addr/din, dout) from an in-order valid/ready request channel and returns one response per request on a valid/ready response channel. It hides the fixed SRAM read latency and guarantees that no read data is ever dropped. It uses credit-based admission against an internal response FIFO. It sits between the core/bus-side data port and the SRAM wrapper's port 0.

---
 rtl/sram_req_ctrl_if.sv | 38 +++
 rtl/sram_req_ctrl.sv | 108 ++++++++++
 tb/tb_sram_req_ctrl.sv | 274 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/sram_req_ctrl_if.sv
// Request/response channel plus the SRAM 1RW port of sram_req_ctrl.
// master: core side and SRAM model; slave: the controller itself.
interface sram_req_ctrl_if #(
  parameter int ADDR_WIDTH = 11,
  parameter int DATA_WIDTH = 32,
  parameter int NUM_WMASKS = 4
);
  logic                  req_valid;
  logic                  req_ready;
  logic                  req_we;
  logic [31:0]           req_addr;
  logic [NUM_WMASKS-1:0] req_be;
  logic [DATA_WIDTH-1:0] req_wdata;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [DATA_WIDTH-1:0] rsp_rdata;
  logic                  rsp_err;
  logic                  sram_csb;
  logic                  sram_web;
  logic [NUM_WMASKS-1:0] sram_wmask;
  logic [ADDR_WIDTH-1:0] sram_addr;
  logic [DATA_WIDTH-1:0] sram_din;
  logic [DATA_WIDTH-1:0] sram_dout;

  modport master (
    output req_valid, req_we, req_addr, req_be, req_wdata,
    output rsp_ready, sram_dout,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err,
    input  sram_csb, sram_web, sram_wmask, sram_addr, sram_din
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_be, req_wdata,
    input  rsp_ready, sram_dout,
    output req_ready, rsp_valid, rsp_rdata, rsp_err,
    output sram_csb, sram_web, sram_wmask, sram_addr, sram_din
  );
endinterface

// File: rtl/sram_req_ctrl.sv
// SRAM request controller: in-order valid/ready requests to a 1RW SRAM
// port, one response per request via a credit-limited response FIFO.
// Ports: clk, rst (async, active high), bus (sram_req_ctrl_if.slave).
// Option: define SRAM_REQ_ERR_EN to reject misaligned/out-of-range addrs.
module sram_req_ctrl #(
  parameter int ADDR_WIDTH = 11,
  parameter int DATA_WIDTH = 32,
  parameter int NUM_WMASKS = 4,
  parameter int RD_LAT     = 2
) (
  input  logic           clk,
  input  logic           rst,
  sram_req_ctrl_if.slave bus
);
  localparam int DEPTH = RD_LAT + 2;
  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = $clog2(DEPTH);
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [PW-1:0] LAST_C = PW'(DEPTH - 1);

  logic [CW-1:0]         occ_q, occ_d;
  logic                  acc, pop, err, hit;
  logic [RD_LAT-1:0]     pv_q, pw_q, pe_q;
  logic                  push, push_err;
  logic [DATA_WIDTH-1:0] push_data;
  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [DEPTH-1:0]      merr_q;
  logic [PW-1:0]         wp_q, rp_q;
  logic [CW-1:0]         cnt_q;

  // occ covers pipeline + FIFO, so a push never finds the FIFO full
  assign bus.req_ready = (occ_q < DEPTH_C) & ~rst;
  assign acc = bus.req_valid & bus.req_ready;

`ifdef SRAM_REQ_ERR_EN
  assign err = (|bus.req_addr[1:0])
             | (|bus.req_addr[31:ADDR_WIDTH+2]);
`else
  logic unused_addr;
  assign unused_addr = ^{bus.req_addr[1:0],
                         bus.req_addr[31:ADDR_WIDTH+2]};
  assign err = 1'b0;
`endif

  assign hit = acc & ~err;

  assign bus.sram_csb   = ~hit;
  assign bus.sram_web   = ~(hit & bus.req_we);
  assign bus.sram_addr  = hit ? bus.req_addr[ADDR_WIDTH+1:2] : '0;
  assign bus.sram_wmask = (hit & bus.req_we) ? bus.req_be : '0;
  assign bus.sram_din   = (hit & bus.req_we) ? bus.req_wdata : '0;

  // pipeline exit lines up with the SRAM read data
  assign push      = pv_q[RD_LAT-1];
  assign push_err  = pe_q[RD_LAT-1];
  assign push_data = (pw_q[RD_LAT-1] | push_err) ? '0 : bus.sram_dout;

  assign bus.rsp_valid = (cnt_q != '0);
  assign bus.rsp_rdata = bus.rsp_valid ? mem_q[rp_q] : '0;
`ifdef SRAM_REQ_ERR_EN
  assign bus.rsp_err   = bus.rsp_valid & merr_q[rp_q];
`else
  assign bus.rsp_err   = 1'b0;
  logic unused_err;
  assign unused_err = ^merr_q;
`endif
  assign pop = bus.rsp_valid & bus.rsp_ready;

  always_comb begin
    occ_d = occ_q;
    if (acc && !pop) occ_d = occ_q + CW'(1);
    else if (!acc && pop) occ_d = occ_q - CW'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      occ_q  <= '0;
      pv_q   <= '0;
      pw_q   <= '0;
      pe_q   <= '0;
      wp_q   <= '0;
      rp_q   <= '0;
      cnt_q  <= '0;
      merr_q <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      occ_q   <= occ_d;
      pv_q[0] <= acc;
      pw_q[0] <= bus.req_we;
      pe_q[0] <= err;
      for (int i = 1; i < RD_LAT; i++) begin
        pv_q[i] <= pv_q[i-1];
        pw_q[i] <= pw_q[i-1];
        pe_q[i] <= pe_q[i-1];
      end
      if (push) begin
        mem_q[wp_q]  <= push_data;
        merr_q[wp_q] <= push_err;
        wp_q <= (wp_q == LAST_C) ? '0 : wp_q + PW'(1);
      end
      if (pop) begin
        rp_q <= (rp_q == LAST_C) ? '0 : rp_q + PW'(1);
      end
      if (push && !pop) cnt_q <= cnt_q + CW'(1);
      else if (!push && pop) cnt_q <= cnt_q - CW'(1);
    end
  end
endmodule

// File: tb/tb_sram_req_ctrl.sv
// Directed bench for sram_req_ctrl with a behavioural RD_LAT=2 SRAM.
// Inputs change 1ns after posedge; outputs sampled on negedge.
module tb_sram_req_ctrl;
  localparam int AW = 11;
  localparam int DW = 32;
  localparam int NW = 4;
  localparam int RL = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   pass_cnt = 0;
  int   total = 0;
  int   n_acc, n_cs;

  sram_req_ctrl_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW),
                     .NUM_WMASKS(NW)) bus ();

  sram_req_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW),
                  .NUM_WMASKS(NW), .RD_LAT(RL)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  logic [DW-1:0] smem [0:(1<<AW)-1];
  logic [DW-1:0] rpipe [RL];

  always @(posedge clk) begin
    if (!bus.sram_csb) begin
      if (!bus.sram_web) begin
        for (int b = 0; b < NW; b++)
          if (bus.sram_wmask[b])
            smem[bus.sram_addr][8*b +: 8] <= bus.sram_din[8*b +: 8];
      end
      rpipe[0] <= smem[bus.sram_addr];
    end
    for (int i = 1; i < RL; i++) rpipe[i] <= rpipe[i-1];
  end
  assign bus.sram_dout = rpipe[RL-1];

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic drive(input logic v, input logic we,
                       input logic [31:0] a, input logic [3:0] be,
                       input logic [31:0] wd);
    bus.req_valid = v;
    bus.req_we    = we;
    bus.req_addr  = a;
    bus.req_be    = be;
    bus.req_wdata = wd;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic get_rsp(input string tag, input logic [31:0] ed,
                         input logic ee);
    bit got = 1'b0;
    for (int i = 0; i < 16 && !got; i++) begin
      @(negedge clk);
      if (bus.rsp_valid) got = 1'b1;
    end
    if (got) begin
      chk({tag, "_data"}, bus.rsp_rdata, ed);
      chk({tag, "_err"}, 32'(bus.rsp_err), 32'(ee));
      tick();
    end else begin
      chk({tag, "_timeout"}, 32'(bus.rsp_valid), 32'd1);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.rsp_ready = 1'b0;
    drive(1'b1, 1'b1, 32'h10, 4'hF, 32'hDEADBEEF);
    #2;
    chk("rst_req_ready", 32'(bus.req_ready), 32'd0);
    chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    chk("rst_rsp_rdata", bus.rsp_rdata, 32'd0);
    chk("rst_rsp_err", 32'(bus.rsp_err), 32'd0);
    chk("rst_csb", 32'(bus.sram_csb), 32'd1);
    chk("rst_web", 32'(bus.sram_web), 32'd1);
    chk("rst_addr", 32'(bus.sram_addr), 32'd0);
    chk("rst_din", bus.sram_din, 32'd0);
    idle();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    chk("post_rst_ready", 32'(bus.req_ready), 32'd1);
    chk("post_rst_occ", 32'(dut.occ_q), 32'd0);

    // write then read of 0x10, exact latency
    tick();
    drive(1'b1, 1'b1, 32'h10, 4'hF, 32'hDEADBEEF);
    @(negedge clk);
    chk("t1_w_csb", 32'(bus.sram_csb), 32'd0);
    chk("t1_w_web", 32'(bus.sram_web), 32'd0);
    chk("t1_w_addr", 32'(bus.sram_addr), 32'd4);
    chk("t1_w_wmask", 32'(bus.sram_wmask), 32'hF);
    chk("t1_w_din", bus.sram_din, 32'hDEADBEEF);
    tick();
    drive(1'b1, 1'b0, 32'h10, 4'hF, 32'h0BADF00D);
    @(negedge clk);
    chk("t1_r_csb", 32'(bus.sram_csb), 32'd0);
    chk("t1_r_web", 32'(bus.sram_web), 32'd1);
    chk("t1_r_addr", 32'(bus.sram_addr), 32'd4);
    chk("t1_r_wmask", 32'(bus.sram_wmask), 32'd0);
    chk("t1_r_din", bus.sram_din, 32'd0);
    tick();
    idle();
    @(negedge clk);
    chk("t1_early", 32'(bus.rsp_valid), 32'd0);
    tick();
    @(negedge clk);
    chk("t1_wr_valid", 32'(bus.rsp_valid), 32'd1);
    chk("t1_wr_rdata", bus.rsp_rdata, 32'd0);
    chk("t1_wr_err", 32'(bus.rsp_err), 32'd0);
    tick();
    @(negedge clk);
    chk("t1_rd_valid", 32'(bus.rsp_valid), 32'd1);
    chk("t1_rd_rdata", bus.rsp_rdata, 32'hDEADBEEF);
    tick();
    @(negedge clk);
    chk("t1_drained", 32'(bus.rsp_valid), 32'd0);

    // preload 1,2,3 then back-to-back reads
    tick();
    drive(1'b1, 1'b1, 32'h0, 4'hF, 32'd1);
    tick();
    drive(1'b1, 1'b1, 32'h4, 4'hF, 32'd2);
    tick();
    drive(1'b1, 1'b1, 32'h8, 4'hF, 32'd3);
    tick();
    idle();
    repeat (6) tick();
    drive(1'b1, 1'b0, 32'h0, 4'h0, 32'h0);
    @(negedge clk);
    chk("t2_ready0", 32'(bus.req_ready), 32'd1);
    tick();
    drive(1'b1, 1'b0, 32'h4, 4'h0, 32'h0);
    @(negedge clk);
    chk("t2_ready1", 32'(bus.req_ready), 32'd1);
    tick();
    drive(1'b1, 1'b0, 32'h8, 4'h0, 32'h0);
    @(negedge clk);
    chk("t2_ready2", 32'(bus.req_ready), 32'd1);
    tick();
    idle();
    @(negedge clk);
    chk("t2_v0", 32'(bus.rsp_valid), 32'd1);
    chk("t2_d0", bus.rsp_rdata, 32'd1);
    tick();
    @(negedge clk);
    chk("t2_v1", 32'(bus.rsp_valid), 32'd1);
    chk("t2_d1", bus.rsp_rdata, 32'd2);
    tick();
    @(negedge clk);
    chk("t2_v2", 32'(bus.rsp_valid), 32'd1);
    chk("t2_d2", bus.rsp_rdata, 32'd3);

    // backpressure: credits stop admission at DEPTH
    tick();
    bus.rsp_ready = 1'b0;
    n_acc = 0;
    n_cs = 0;
    for (int c = 0; c < 10; c++) begin
      drive(1'b1, 1'b0, 32'((n_acc % 3) * 4), 4'h0, 32'h0);
      @(negedge clk);
      if (!bus.sram_csb) n_cs++;
      if (bus.req_ready) n_acc++;
      tick();
    end
    chk("t3_accepts", 32'(n_acc), 32'd4);
    chk("t3_csb_pulses", 32'(n_cs), 32'd4);
    chk("t3_ready_low", 32'(bus.req_ready), 32'd0);
    idle();
    @(negedge clk);
    chk("t3_hold_v", 32'(bus.rsp_valid), 32'd1);
    chk("t3_hold_d0", bus.rsp_rdata, 32'd1);
    tick();
    @(negedge clk);
    chk("t3_hold_d1", bus.rsp_rdata, 32'd1);
    tick();
    bus.rsp_ready = 1'b1;
    get_rsp("t3_r0", 32'd1, 1'b0);
    get_rsp("t3_r1", 32'd2, 1'b0);
    get_rsp("t3_r2", 32'd3, 1'b0);
    get_rsp("t3_r3", 32'd1, 1'b0);
    @(negedge clk);
    chk("t3_empty", 32'(bus.rsp_valid), 32'd0);
    chk("t3_occ", 32'(dut.occ_q), 32'd0);

    // partial write
    tick();
    drive(1'b1, 1'b1, 32'h20, 4'hF, 32'hFFFFFFFF);
    tick();
    drive(1'b1, 1'b1, 32'h20, 4'b0011, 32'h12345678);
    @(negedge clk);
    chk("t4_wmask", 32'(bus.sram_wmask), 32'h3);
    tick();
    drive(1'b1, 1'b0, 32'h20, 4'h0, 32'h0);
    tick();
    idle();
    get_rsp("t4_w0", 32'd0, 1'b0);
    get_rsp("t4_w1", 32'd0, 1'b0);
    get_rsp("t4_rd", 32'hFFFF5678, 1'b0);

    // reset with reads in flight
    drive(1'b1, 1'b0, 32'h0, 4'h0, 32'h0);
    tick();
    drive(1'b1, 1'b0, 32'h4, 4'h0, 32'h0);
    tick();
    drive(1'b1, 1'b0, 32'h8, 4'h0, 32'h0);
    tick();
    drive(1'b1, 1'b0, 32'hC, 4'h0, 32'h0);
    chk("t5_pre_valid", 32'(bus.rsp_valid), 32'd1);
    rst = 1'b1;
    #1;
    chk("t5_rst_valid", 32'(bus.rsp_valid), 32'd0);
    chk("t5_rst_csb", 32'(bus.sram_csb), 32'd1);
    chk("t5_rst_ready", 32'(bus.req_ready), 32'd0);
    chk("t5_rst_rdata", bus.rsp_rdata, 32'd0);
    @(posedge clk);
    #1;
    idle();
    rst = 1'b0;
    @(negedge clk);
    chk("t5_occ", 32'(dut.occ_q), 32'd0);
    chk("t5_ready", 32'(bus.req_ready), 32'd1);
    repeat (4) tick();
    @(negedge clk);
    chk("t5_no_rsp", 32'(bus.rsp_valid), 32'd0);

    // misaligned, out-of-range read
    tick();
    drive(1'b1, 1'b0, 32'h2001, 4'h0, 32'h0);
    @(negedge clk);
`ifdef SRAM_REQ_ERR_EN
    chk("t6_csb", 32'(bus.sram_csb), 32'd1);
    tick();
    idle();
    get_rsp("t6_rsp", 32'd0, 1'b1);
`else
    chk("t6_csb", 32'(bus.sram_csb), 32'd0);
    chk("t6_addr", 32'(bus.sram_addr), 32'd0);
    tick();
    idle();
    get_rsp("t6_rsp", 32'd1, 1'b0);
`endif

    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end
endmodule
